// File: rtl/ifetch_pkg.sv
// Shared types and sizing for the instruction prefetch unit.
// IFETCH_DEEP_PREFETCH_EN selects a 4-entry buffer instead of 2.
package ifetch_pkg;

    localparam int INST_WIDTH = 8;
    localparam int INST_DEPTH = 8;

`ifdef IFETCH_DEEP_PREFETCH_EN
    localparam int IFETCH_DEPTH = 4;
`else
    localparam int IFETCH_DEPTH = 2;
`endif

    localparam int CNT_W = $clog2(IFETCH_DEPTH + 1);
    localparam int PTR_W = $clog2(IFETCH_DEPTH);

    typedef enum logic [1:0] {
        IFETCH_IDLE  = 2'd0,
        IFETCH_REQ   = 2'd1,
        IFETCH_DRAIN = 2'd2
    } state_t;

    function automatic logic [PTR_W-1:0] ptr_next(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(IFETCH_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/ifetch_if.sv
// Program-memory read bus: mem_req/mem_addr out, mem_ack/mem_rdata back.
// master = fetch unit, slave = program memory.
interface ifetch_if;
    import ifetch_pkg::*;

    logic                  mem_req;
    logic [INST_DEPTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [INST_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/ifetch_fifo.sv
// Prefetch byte FIFO: push/pop/flush in, head byte and occupancy out.
// Flush wins over push and pop; pop on empty is ignored; head is 0 when empty.
module ifetch_fifo
    import ifetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  flush,
    input  logic [INST_WIDTH-1:0] wdata,
    output logic [INST_WIDTH-1:0] head,
    output logic [CNT_W-1:0]      count
);

    logic [INST_WIDTH-1:0] mem [IFETCH_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic                  do_push;
    logic                  do_pop;
    logic                  full;

    assign full    = (count == CNT_W'(IFETCH_DEPTH));
    assign do_pop  = pop && (count != '0) && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_next(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ifetch.sv
// Instruction prefetch: fetch FSM + fetch address feeding a byte FIFO.
// Ports: clk, rst, pc_load/jump_addr (jump), imem_update (pop),
// imem_data/imem_valid (head), bus (program-memory master).
// IFETCH_DEEP_PREFETCH_EN (see ifetch_pkg) deepens the buffer to 4.
module ifetch
    import ifetch_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_load,
    input  logic [INST_DEPTH-1:0] jump_addr,
    input  logic                  imem_update,
    output logic [INST_WIDTH-1:0] imem_data,
    output logic                  imem_valid,
    ifetch_if.master              bus
);

    state_t                state;
    state_t                state_nx;
    logic [INST_DEPTH-1:0] faddr;
    logic [INST_DEPTH-1:0] drain_addr;
    logic [CNT_W-1:0]      count;
    logic                  push;
    logic                  pop_eff;
    logic                  full_after;

    assign push    = (state == IFETCH_REQ) && bus.mem_ack;
    assign pop_eff = imem_update && (count != '0);

    // A push in REQ fills the buffer only if no pop frees a slot.
    assign full_after = (count == CNT_W'(IFETCH_DEPTH - 1)) && !pop_eff;

    ifetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (imem_update),
        .flush (pc_load),
        .wdata (bus.mem_rdata),
        .head  (imem_data),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IFETCH_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IFETCH_IDLE: begin
                if (pc_load || count < CNT_W'(IFETCH_DEPTH))
                    state_nx = IFETCH_REQ;
            end
            IFETCH_REQ: begin
                if (bus.mem_ack) begin
                    if (!pc_load && full_after)
                        state_nx = IFETCH_IDLE;
                end else if (pc_load) begin
                    state_nx = IFETCH_DRAIN;
                end
            end
            IFETCH_DRAIN: begin
                if (bus.mem_ack)
                    state_nx = IFETCH_REQ;
            end
            default: state_nx = IFETCH_IDLE;
        endcase
    end

    // The outstanding address is parked in drain_addr so faddr can
    // take the jump target while the old read is still in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            faddr      <= '0;
            drain_addr <= '0;
        end else begin
            if (state == IFETCH_REQ && pc_load && !bus.mem_ack)
                drain_addr <= faddr;
            if (pc_load)
                faddr <= jump_addr;
            else if (push)
                faddr <= faddr + 1'b1;
        end
    end

    assign bus.mem_req  = (state != IFETCH_IDLE);
    assign bus.mem_addr = (state == IFETCH_DRAIN) ? drain_addr : faddr;
    assign imem_valid   = (count != '0);

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: directed scenarios plus a randomized run
// against a queue-based model of the prefetch buffer and fetch address.
module tb_ifetch;
    import ifetch_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  pc_load;
    logic [INST_DEPTH-1:0] jump_addr;
    logic                  imem_update;
    logic [INST_WIDTH-1:0] imem_data;
    logic                  imem_valid;

    ifetch_if bus ();

    ifetch dut (
        .clk         (clk),
        .rst         (rst),
        .pc_load     (pc_load),
        .jump_addr   (jump_addr),
        .imem_update (imem_update),
        .imem_data   (imem_data),
        .imem_valid  (imem_valid),
        .bus         (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 0 never ack, 1 ack when requested, 2 random ack, 4 ack always
    int ack_mode = 0;
    bit resp_ack;

    always @(negedge clk) begin
        #1;
        case (ack_mode)
            1:       resp_ack = bus.mem_req;
            2:       resp_ack = 1'($urandom_range(0, 1));
            4:       resp_ack = 1'b1;
            default: resp_ack = 1'b0;
        endcase
        bus.mem_ack   = resp_ack;
        bus.mem_rdata = (resp_ack && bus.mem_req) ?
                        8'hA0 + bus.mem_addr : 8'($urandom);
    end

    // Reference model: buffer as a queue, fetch address, pending discard.
    logic [7:0] q[$];
    logic [7:0] m_faddr;
    logic [7:0] drain_addr;
    bit         draining;
    bit         hold_exp;
    logic [7:0] hold_addr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            m_faddr  = 8'h00;
            draining = 1'b0;
            hold_exp = 1'b0;
        end else begin
            hold_exp  = bus.mem_req && !bus.mem_ack;
            hold_addr = bus.mem_addr;
            if (pc_load) begin
                if (bus.mem_req && !bus.mem_ack) begin
                    if (!draining) drain_addr = m_faddr;
                    draining = 1'b1;
                end else begin
                    draining = 1'b0;
                end
                q.delete();
                m_faddr = jump_addr;
            end else begin
                if (imem_update && q.size() != 0) void'(q.pop_front());
                if (bus.mem_req && bus.mem_ack) begin
                    if (draining) begin
                        draining = 1'b0;
                    end else begin
                        q.push_back(8'hA0 + m_faddr);
                        m_faddr = m_faddr + 8'h01;
                    end
                end
            end
        end
    end

    function automatic logic [7:0] exp_addr();
        return draining ? drain_addr : m_faddr;
    endfunction

    task automatic wait_full(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (q.size() == IFETCH_DEPTH && !bus.mem_req) break;
            @(negedge clk);
        end
        checks++;
        if (q.size() != IFETCH_DEPTH || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_fill_timeout got size %0d req %b exp %0d 0",
                     tag, q.size(), bus.mem_req, IFETCH_DEPTH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_load = 1'b0; imem_update = 1'b0;
        jump_addr = '0; ack_mode = 0;
        repeat (3) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", bus.mem_req); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got %h exp 00", bus.mem_addr); end
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", imem_valid); end
        checks++; if (imem_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", imem_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", bus.mem_req); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL first_addr got %h exp 00", bus.mem_addr); end
    endtask

    task automatic test_fill();
        int k = 0;
        ack_mode = 1;
        for (int i = 0; i < 20; i++) begin
            if (q.size() == IFETCH_DEPTH) break;
            if (bus.mem_req) begin
                checks++;
                if (bus.mem_addr !== 8'(k)) begin errors++; $display("FAIL fill_addr got %h exp %h", bus.mem_addr, 8'(k)); end
                k++;
            end
            @(negedge clk);
        end
        checks++; if (k != IFETCH_DEPTH) begin errors++; $display("FAIL fill_reqs got %0d exp %0d", k, IFETCH_DEPTH); end
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_drop got %b exp 0", bus.mem_req); end
        checks++; if (imem_valid !== 1'b1) begin errors++; $display("FAIL fill_valid got %b exp 1", imem_valid); end
        checks++; if (imem_data !== 8'hA0) begin errors++; $display("FAIL fill_data got %h exp a0", imem_data); end
        repeat (2) @(negedge clk);
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL fill_req_stay got %b exp 0", bus.mem_req); end
    endtask

    task automatic test_stream();
        logic [7:0] exp = 8'hA0;
        int pops = 0;
        ack_mode = 1;
        imem_update = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (imem_valid) begin
                checks++;
                if (imem_data !== exp) begin errors++; $display("FAIL stream_data got %h exp %h", imem_data, exp); end
                exp = exp + 8'h01;
                pops++;
            end
            if (i >= 30) begin
                checks++;
                if (imem_valid !== 1'b1) begin errors++; $display("FAIL stream_steady got %b exp 1", imem_valid); end
            end
            @(negedge clk);
        end
        imem_update = 1'b0;
        checks++; if (pops < 30) begin errors++; $display("FAIL stream_rate got %0d exp >=30", pops); end
    endtask

    task automatic test_jump_full();
        ack_mode = 1;
        wait_full("jump");
        pc_load = 1'b1; jump_addr = 8'h40;
        @(negedge clk);
        pc_load = 1'b0;
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL jump_flush got %b exp 0", imem_valid); end
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h40) begin errors++; $display("FAIL jump_addr got %b/%h exp 1/40", bus.mem_req, bus.mem_addr); end
        @(negedge clk);
        checks++; if (imem_valid !== 1'b1 || imem_data !== 8'hE0) begin errors++; $display("FAIL jump_data got %b/%h exp 1/e0", imem_valid, imem_data); end
    endtask

    task automatic test_drain();
        ack_mode = 1;
        wait_full("drain");
        ack_mode = 0;
        pc_load = 1'b1; jump_addr = 8'h05;
        @(negedge clk);
        pc_load = 1'b0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h05) begin errors++; $display("FAIL drain_req5 got %b/%h exp 1/05", bus.mem_req, bus.mem_addr); end
        pc_load = 1'b1; jump_addr = 8'h30;
        @(negedge clk);
        jump_addr = 8'h10;
        @(negedge clk);
        pc_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h05 || imem_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_hold got %b/%h/%b exp 1/05/0", bus.mem_req, bus.mem_addr, imem_valid);
            end
            @(negedge clk);
        end
        ack_mode = 1;
        @(negedge clk);
        checks++; if (bus.mem_addr !== 8'h10) begin errors++; $display("FAIL drain_next got %h exp 10", bus.mem_addr); end
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL drain_discard got %b exp 0", imem_valid); end
        @(negedge clk);
        checks++; if (imem_valid !== 1'b1 || imem_data !== 8'hB0) begin errors++; $display("FAIL drain_data got %b/%h exp 1/b0", imem_valid, imem_data); end
    endtask

    task automatic test_ack_no_req();
        ack_mode = 1;
        wait_full("noreq");
        ack_mode = 4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.mem_req !== 1'b0 || imem_data !== 8'hB0) begin
                errors++;
                $display("FAIL noreq_ignore got %b/%h exp 0/b0", bus.mem_req, imem_data);
            end
        end
        ack_mode = 0;
        imem_update = 1'b1;
        for (int i = 0; i < IFETCH_DEPTH; i++) begin
            checks++;
            if (imem_valid !== 1'b1 || imem_data !== 8'hB0 + 8'(i)) begin
                errors++;
                $display("FAIL noreq_order got %b/%h exp 1/%h", imem_valid, imem_data, 8'hB0 + 8'(i));
            end
            @(negedge clk);
        end
        imem_update = 1'b0;
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL noreq_extra got %b exp 0", imem_valid); end
    endtask

    task automatic test_wrap_empty();
        ack_mode = 1;
        wait_full("wrap");
        ack_mode = 0;
        pc_load = 1'b1; jump_addr = 8'hFF;
        @(negedge clk);
        pc_load = 1'b0;
        checks++; if (bus.mem_addr !== 8'hFF) begin errors++; $display("FAIL wrap_ff got %h exp ff", bus.mem_addr); end
        ack_mode = 1;
        @(negedge clk);
        ack_mode = 0;
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin errors++; $display("FAIL wrap_zero got %b/%h exp 1/00", bus.mem_req, bus.mem_addr); end
        checks++; if (imem_data !== 8'h9F) begin errors++; $display("FAIL wrap_data got %h exp 9f", imem_data); end
        imem_update = 1'b1;
        repeat (3) @(negedge clk);
        imem_update = 1'b0;
        checks++; if (imem_valid !== 1'b0) begin errors++; $display("FAIL empty_valid got %b exp 0", imem_valid); end
        checks++; if (imem_data !== 8'h00) begin errors++; $display("FAIL empty_data got %h exp 00", imem_data); end
        @(negedge clk);
        checks++; if (imem_valid !== 1'b0 || q.size() != 0) begin errors++; $display("FAIL empty_underflow got %b exp 0", imem_valid); end
    endtask

    task automatic test_reset_mid();
        ack_mode = 1;
        @(negedge clk);
        ack_mode = 0;
        checks++; if (imem_valid !== 1'b1 || bus.mem_req !== 1'b1) begin errors++; $display("FAIL mid_setup got %b/%b exp 1/1", imem_valid, bus.mem_req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL mid_req got %b exp 0", bus.mem_req); end
        checks++; if (imem_valid !== 1'b0 || imem_data !== 8'h00) begin errors++; $display("FAIL mid_valid got %b/%h exp 0/00", imem_valid, imem_data); end
        checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL mid_addr got %h exp 00", bus.mem_addr); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 8'h00) begin errors++; $display("FAIL mid_restart got %b/%h exp 1/00", bus.mem_req, bus.mem_addr); end
    endtask

    task automatic test_random();
        int starve = 0;
        ack_mode = 2;
        for (int i = 0; i < 800; i++) begin
            checks++;
            if (imem_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", i, imem_valid, q.size() != 0); end
            checks++;
            if (imem_data !== ((q.size() != 0) ? q[0] : 8'h00)) begin
                errors++;
                $display("FAIL rnd_data cyc %0d got %h exp %h", i, imem_data, (q.size() != 0) ? q[0] : 8'h00);
            end
            if (bus.mem_req) begin
                checks++;
                if (bus.mem_addr !== exp_addr()) begin errors++; $display("FAIL rnd_addr cyc %0d got %h exp %h", i, bus.mem_addr, exp_addr()); end
            end
            if (hold_exp) begin
                checks++;
                if (bus.mem_req !== 1'b1 || bus.mem_addr !== hold_addr) begin
                    errors++;
                    $display("FAIL rnd_hold cyc %0d got %b/%h exp 1/%h", i, bus.mem_req, bus.mem_addr, hold_addr);
                end
            end
            if (!draining && q.size() == IFETCH_DEPTH) begin
                checks++;
                if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rnd_full_req cyc %0d got %b exp 0", i, bus.mem_req); end
            end
            if (!bus.mem_req && q.size() < IFETCH_DEPTH) starve++;
            else starve = 0;
            checks++;
            if (starve > 1) begin errors++; $display("FAIL rnd_starve cyc %0d got %0d exp <=1", i, starve); end
            imem_update = 1'($urandom_range(0, 1));
            pc_load = ($urandom_range(0, 15) == 0);
            jump_addr = ($urandom_range(0, 3) == 0) ?
                        8'hFE + 8'($urandom_range(0, 1)) : 8'($urandom);
            @(negedge clk);
        end
        pc_load = 1'b0;
        imem_update = 1'b0;
        ack_mode = 0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_fill();
        test_stream();
        test_jump_full();
        test_drain();
        test_ack_no_req();
        test_wrap_empty();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL have `clk  in  1`: the single system clock; all state changes on its rising edge.
REQ-002 The block SHALL have `rst  in  1`: reset, asynchronous and active-high.
REQ-003 The block SHALL have `pc_load  in  1`: jump strobe from mcu; flushes the buffer.
REQ-004 The block SHALL have `jump_addr  in  INST_DEPTH`: jump target (ALU result), sampled when pc_load=1.
REQ-005 The block SHALL have `imem_update  in  1`: consumer pop strobe from mcu.
REQ-006 The block SHALL have `imem_data  out  INST_WIDTH`: head-of-buffer byte, fed to regs.imem_data.
REQ-007 The block SHALL have `imem_valid  out  1`: buffer non-empty.
REQ-008 The block SHALL have `mem_req  out  1`: program-memory read request.
REQ-009 The block SHALL have `mem_addr  out  INST_DEPTH`: program-memory read address.
REQ-010 The block SHALL have `mem_ack  in  1`: read complete; mem_rdata valid this cycle.
REQ-011 The block SHALL have `mem_rdata  in  INST_WIDTH`: program-memory read data.

Function
REQ-012 The block SHALL implement a FIFO prefetch buffer of IFETCH_DEPTH bytes, with a fetch address register faddr and a state machine {IDLE, REQ, DRAIN}.
REQ-013 In IDLE with count < IFETCH_DEPTH, the block SHALL enter REQ next cycle, driving mem_req=1 and mem_addr=faddr.
REQ-014 In REQ, mem_req and mem_addr SHALL hold stable until mem_ack=1 is sampled at a rising edge.
REQ-015 On that edge, mem_rdata SHALL be pushed and faddr SHALL increment; the state SHALL be REQ if count after push < IFETCH_DEPTH, else IDLE.
REQ-016 mem_ack with mem_req=0 SHALL be ignored.
REQ-017 faddr SHALL wrap from 2^INST_DEPTH-1 to 0.
REQ-018 imem_data SHALL equal the head entry whenever imem_valid=1, and SHALL be 0 when the buffer is empty.
REQ-019 imem_update with imem_valid=1 SHALL pop one entry; imem_update with an empty buffer SHALL be ignored with no underflow.
REQ-020 A simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-021 pc_load=1 SHALL, at that edge, empty the buffer and load faddr<=jump_addr; a coincident pop or push SHALL be discarded.
REQ-022 pc_load=1 in REQ without mem_ack SHALL move the state to DRAIN. In DRAIN, mem_req SHALL stay high at the old address until mem_ack, and that data SHALL be discarded; the state SHALL then go to REQ at the new faddr.
REQ-023 A further pc_load during DRAIN SHALL reload faddr and stay in DRAIN.
REQ-024 Minimum latency SHALL be: ack edge -> imem_valid=1 immediately after that edge; first mem_req SHALL be 1 cycle after rst deasserts.

Reset
REQ-025 While rst=1, the block SHALL hold state=IDLE, faddr=0, count=0, mem_req=0, mem_addr=0, imem_valid=0, imem_data=0.
REQ-026 rst asserted mid-request SHALL abandon the transaction, with no DRAIN afterwards.

Configuration
REQ-027 With macro IFETCH_DEEP_PREFETCH_EN defined, IFETCH_DEPTH SHALL be 4.
REQ-028 Without IFETCH_DEEP_PREFETCH_EN, IFETCH_DEPTH SHALL be 2; all other behaviour SHALL be identical.

Structure
REQ-029 defs.v SHALL hold IFETCH_DEPTH, the IFETCH_IDLE/REQ/DRAIN state encodings, and the use of the existing INST_WIDTH and INST_DEPTH.
REQ-030 The storage SHALL be a sub-module ifetch_fifo (push, pop, flush, head, count); ifetch SHALL contain the FSM and faddr.

Verification
REQ-031 Reset then memory acking every cycle with rdata=0xA0+addr -> mem_addr 0,1,... in order; buffer fills to IFETCH_DEPTH; mem_req drops; imem_data=0xA0.
REQ-032 Pop every cycle with ack every cycle -> imem_data stream 0xA0,0xA1,0xA2... with no gaps or duplicates; count constant.
REQ-033 pc_load with jump_addr=0x40 while the buffer is full -> imem_valid=0 next cycle; next mem_addr=0x40; first byte delivered=0xE0.
REQ-034 pc_load with jump_addr=0x10 during REQ at addr 0x05, ack delayed 3 cycles -> DRAIN; byte for 0x05 discarded; next mem_addr=0x10.
REQ-035 faddr=2^INST_DEPTH-1 fetched -> next mem_addr=0; pop on empty -> count stays 0, imem_data=0.
REQ-036 rst asserted while mem_req=1 -> mem_req=0 and imem_valid=0 immediately; after release, the fetch restarts at 0.
